// File: rtl/credit_arbiter.sv
// Round-robin arbiter sharing one credit pool between NumReq requesters.
// Granted requests leave through a registered valid/ready stage.
module credit_arbiter #(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned Width      = 8,
    parameter int unsigned MaxCredit  = 255,
    parameter int unsigned InitCredit = MaxCredit,
    parameter bit          Reserve    = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic [NumReq-1:0]          req_valid_i,
    input  logic [NumReq*Width-1:0]    req_amount_i,
    output logic [NumReq-1:0]          req_ready_o,
    output logic                       gnt_valid_o,
    output logic [$clog2(NumReq)-1:0]  gnt_idx_o,
    output logic [Width-1:0]           gnt_amount_o,
    input  logic                       gnt_ready_i,
    input  logic                       ret_valid_i,
    input  logic [Width-1:0]           ret_amount_i,
    output logic [Width-1:0]           credit_o,
    output logic                       overflow_o,
    output logic                       busy_o
);
    localparam int unsigned          IdxW    = $clog2(NumReq);
    localparam logic [Width-1:0]     MAX_C   = Width'(MaxCredit);
    localparam logic [Width-1:0]     INIT_C  = Width'(InitCredit);
    localparam logic [Width:0]       SUM_MAX = (Width+1)'(MaxCredit);
    localparam logic [IdxW-1:0]      LAST    = IdxW'(NumReq - 1);

    logic [Width-1:0]  r_credit;
    logic [IdxW-1:0]   r_ptr;
    logic              r_overflow;
    logic              r_vld_p1;
    logic [IdxW-1:0]   r_idx_p1;
    logic [Width-1:0]  r_amt_p1;

    logic              w_slot_free;
    logic [NumReq-1:0] w_elig;
    logic [NumReq-1:0] w_ready;
    logic              w_xfer;
    logic [IdxW-1:0]   w_win_idx;
    logic [IdxW-1:0]   w_cand;
    logic [Width-1:0]  w_win_amt;
    logic [Width:0]    w_sum;
    logic [IdxW-1:0]   w_ptr_next;

    function automatic logic [Width-1:0] sat_credit(input logic [Width:0] sum);
        return (sum > SUM_MAX) ? MAX_C : sum[Width-1:0];
    endfunction

    assign w_slot_free = !r_vld_p1 || gnt_ready_i;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            w_elig[i] = req_valid_i[i] && (req_amount_i[i*Width +: Width] <= r_credit);
        end
    end

    // Search upward from the pointer; with Reserve the pointer parks on a starved requester.
    always_comb begin
        int j;
        w_ready   = '0;
        w_xfer    = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        j         = 0;
        if (w_slot_free && !rst_i && !clear_i &&
            !(Reserve && req_valid_i[r_ptr] && !w_elig[r_ptr])) begin
            for (int k = 0; k < NumReq; k++) begin
                j = int'(r_ptr) + k;
                if (j >= int'(NumReq)) j = j - int'(NumReq);
                w_cand = IdxW'(j);
                if (!w_xfer && w_elig[w_cand]) begin
                    w_xfer    = 1'b1;
                    w_win_idx = w_cand;
                end
            end
        end
        if (w_xfer) w_ready[w_win_idx] = 1'b1;
    end

    assign w_win_amt  = req_amount_i[w_win_idx*Width +: Width];
    assign w_ptr_next = (w_win_idx == LAST) ? '0 : w_win_idx + 1'b1;

    // Eligibility guarantees the subtraction never goes below zero.
    assign w_sum = {1'b0, r_credit}
                 - (w_xfer      ? {1'b0, w_win_amt}    : '0)
                 + (ret_valid_i ? {1'b0, ret_amount_i} : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_credit   <= INIT_C;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_idx_p1   <= '0;
            r_amt_p1   <= '0;
        end else begin
            r_credit <= sat_credit(w_sum);
            if (w_sum > SUM_MAX) r_overflow <= 1'b1;
            // Output stage boundary: grant captured into the p1 register.
            if (w_xfer) begin
                r_vld_p1 <= 1'b1;
                r_idx_p1 <= w_win_idx;
                r_amt_p1 <= w_win_amt;
                r_ptr    <= w_ptr_next;
            end else if (gnt_ready_i) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign req_ready_o  = w_ready;
    assign gnt_valid_o  = r_vld_p1;
    assign gnt_idx_o    = r_idx_p1;
    assign gnt_amount_o = r_amt_p1;
    assign credit_o     = r_credit;
    assign overflow_o   = r_overflow;
    assign busy_o       = (r_credit != INIT_C) || r_vld_p1;
endmodule

// File: tb/tb_credit_arbiter.sv
// Bench for credit_arbiter: directed stimulus, grant scoreboard drained by a monitor,
// plus a second instance with Reserve=0 for the skip behaviour.
module tb_credit_arbiter;
    logic        clk = 1'b0;
    logic        rst, clear;
    logic [3:0]  req_valid;
    logic [31:0] req_amount;
    logic        gnt_ready, ret_valid;
    logic [7:0]  ret_amount;
    logic [3:0]  req_ready;
    logic        gnt_valid;
    logic [1:0]  gnt_idx;
    logic [7:0]  gnt_amount, credit;
    logic        overflow, busy;

    logic [3:0]  b_req_valid;
    logic [31:0] b_req_amount;
    logic        b_ret_valid;
    logic [7:0]  b_ret_amount;
    logic [3:0]  b_req_ready;
    logic        b_gnt_valid;
    logic [1:0]  b_gnt_idx;
    logic [7:0]  b_gnt_amount, b_credit;
    logic        b_overflow, b_busy;

    int checks = 0;
    int failures = 0;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    credit_arbiter #(.NumReq(4), .Width(8), .MaxCredit(255), .InitCredit(255), .Reserve(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .req_valid_i(req_valid), .req_amount_i(req_amount), .req_ready_o(req_ready),
        .gnt_valid_o(gnt_valid), .gnt_idx_o(gnt_idx), .gnt_amount_o(gnt_amount),
        .gnt_ready_i(gnt_ready), .ret_valid_i(ret_valid), .ret_amount_i(ret_amount),
        .credit_o(credit), .overflow_o(overflow), .busy_o(busy)
    );

    credit_arbiter #(.NumReq(4), .Width(8), .MaxCredit(255), .InitCredit(255), .Reserve(1'b0)) u_dut_skip (
        .clk_i(clk), .rst_i(rst), .clear_i(1'b0),
        .req_valid_i(b_req_valid), .req_amount_i(b_req_amount), .req_ready_o(b_req_ready),
        .gnt_valid_o(b_gnt_valid), .gnt_idx_o(b_gnt_idx), .gnt_amount_o(b_gnt_amount),
        .gnt_ready_i(1'b1), .ret_valid_i(b_ret_valid), .ret_amount_i(b_ret_amount),
        .credit_o(b_credit), .overflow_o(b_overflow), .busy_o(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted grant must match the oldest expected grant.
    always @(negedge clk) begin
        if (gnt_valid === 1'b1 && gnt_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL gnt_unexpected: got idx %0d amt %0d expected none", gnt_idx, gnt_amount);
            end else begin
                logic [9:0] e;
                e = q.pop_front();
                chk("gnt_idx", gnt_idx, e[9:8]);
                chk("gnt_amt", gnt_amount, e[7:0]);
            end
        end
    end

    initial begin
        rst = 1; clear = 0; req_valid = 4'hF; req_amount = '0; gnt_ready = 1;
        ret_valid = 0; ret_amount = 0;
        b_req_valid = 0; b_req_amount = '0; b_ret_valid = 0; b_ret_amount = 0;
        tick; tick;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_credit", credit, 255);
        chk("rst_gvld", gnt_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        tick;

        // Round robin, all requesters at amount 10
        rst = 0; req_amount = {4{8'd10}};
        for (int n = 0; n < 5; n++) begin
            q.push_back({2'(n % 4), 8'd10});
            @(negedge clk);
            chk("rr_ready", req_ready, 1 << (n % 4));
            chk("rr_credit", credit, 255 - 10 * n);
            tick;
        end
        req_valid = 0;
        @(negedge clk);
        chk("rr_credit_end", credit, 205);
        chk("rr_gvld", gnt_valid, 1);
        tick;
        @(negedge clk);
        chk("rr_gvld_drop", gnt_valid, 0);
        tick;

        clear = 1; req_valid = 4'b0001; ret_valid = 1; ret_amount = 5;
        @(negedge clk);
        chk("clr_ready", req_ready, 0);
        tick;
        clear = 0; req_valid = 0; ret_valid = 0;
        @(negedge clk);
        chk("clr_credit", credit, 255);
        chk("clr_gvld", gnt_valid, 0);
        tick;

        // Reserve=1: pointer parks on a starved requester
        req_valid = 4'b0001; req_amount = {8'd0, 8'd5, 8'd100, 8'd200};
        q.push_back({2'd0, 8'd200});
        @(negedge clk);
        chk("res_ready0", req_ready, 4'b0001);
        tick;
        req_valid = 4'b0110;
        repeat (2) begin
            @(negedge clk);
            chk("res_blocked", req_ready, 0);
            chk("res_credit55", credit, 55);
            tick;
        end
        ret_valid = 1; ret_amount = 50;
        @(negedge clk);
        chk("res_ret_same_cycle", req_ready, 0);
        tick;
        ret_valid = 0;
        q.push_back({2'd1, 8'd100});
        @(negedge clk);
        chk("res_ready1", req_ready, 4'b0010);
        chk("res_credit105", credit, 105);
        tick;
        req_valid = 0;
        @(negedge clk);
        chk("res_credit5", credit, 5);
        chk("res_busy", busy, 1);
        tick;
        ret_valid = 1; ret_amount = 250;
        tick;
        ret_valid = 0;
        @(negedge clk);
        chk("ret_to_max", credit, 255);
        chk("ret_to_max_ovf", overflow, 0);
        tick;
        clear = 1;
        tick;
        clear = 0;

        // Backpressure holds the output stage
        req_valid = 4'b0011; req_amount = {4{8'd10}};
        q.push_back({2'd0, 8'd10});
        @(negedge clk);
        chk("bp_ready0", req_ready, 4'b0001);
        tick;
        gnt_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", req_ready, 0);
            chk("bp_gvld", gnt_valid, 1);
            chk("bp_idx", gnt_idx, 0);
            chk("bp_amt", gnt_amount, 10);
            chk("bp_credit", credit, 245);
            tick;
        end
        gnt_ready = 1;
        q.push_back({2'd1, 8'd10});
        @(negedge clk);
        chk("bp_ready1", req_ready, 4'b0010);
        tick;
        req_valid = 0;
        @(negedge clk);
        chk("bp_next_idx", gnt_idx, 1);
        chk("bp_credit2", credit, 235);
        tick;

        // Overflow saturation and sticky flag
        ret_valid = 1; ret_amount = 15;
        tick;
        ret_amount = 20;
        @(negedge clk);
        chk("ovf_credit250", credit, 250);
        chk("ovf_pre", overflow, 0);
        tick;
        ret_valid = 0;
        @(negedge clk);
        chk("ovf_credit_sat", credit, 255);
        chk("ovf_set", overflow, 1);
        tick;
        @(negedge clk);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_busy", busy, 0);
        tick;
        clear = 1; ret_valid = 1; ret_amount = 5; req_valid = 4'b0001;
        @(negedge clk);
        chk("clr2_ready", req_ready, 0);
        tick;
        clear = 0; ret_valid = 0; req_amount[7:0] = 8'd155;
        q.push_back({2'd0, 8'd155});
        @(negedge clk);
        chk("clr2_ovf", overflow, 0);
        chk("clr2_credit", credit, 255);
        chk("clr2_gvld", gnt_valid, 0);
        chk("clr2_ptr0", req_ready, 4'b0001);
        tick;

        // Simultaneous grant and return, then reset mid-burst
        req_valid = 4'b0010; req_amount[15:8] = 8'd30; ret_valid = 1; ret_amount = 12;
        q.push_back({2'd1, 8'd30});
        @(negedge clk);
        chk("sim_credit100", credit, 100);
        chk("sim_ready", req_ready, 4'b0010);
        tick;
        ret_valid = 0; req_valid = 4'b1111; req_amount = {4{8'd10}};
        q.push_back({2'd2, 8'd10});
        @(negedge clk);
        chk("sim_credit82", credit, 82);
        chk("burst_ready2", req_ready, 4'b0100);
        tick;
        q.push_back({2'd3, 8'd10});
        @(negedge clk);
        chk("burst_ready3", req_ready, 4'b1000);
        chk("burst_credit", credit, 72);
        tick;
        rst = 1;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 0);
        tick;
        rst = 0; req_valid = 0;
        @(negedge clk);
        chk("mid_rst_credit", credit, 255);
        chk("mid_rst_gvld", gnt_valid, 0);
        chk("mid_rst_idx", gnt_idx, 0);
        chk("mid_rst_amt", gnt_amount, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_busy", busy, 0);
        tick;

        // Reserve=0 instance: starved requester is skipped
        b_req_valid = 4'b0001; b_req_amount = {8'd0, 8'd5, 8'd100, 8'd200};
        @(negedge clk);
        chk("skip_ready0", b_req_ready, 4'b0001);
        tick;
        b_req_valid = 4'b0110;
        @(negedge clk);
        chk("skip_ready2", b_req_ready, 4'b0100);
        chk("skip_credit55", b_credit, 55);
        tick;
        b_req_valid = 4'b0010;
        @(negedge clk);
        chk("skip_wait", b_req_ready, 0);
        chk("skip_credit50", b_credit, 50);
        chk("skip_gidx2", b_gnt_idx, 2);
        tick;
        b_ret_valid = 1; b_ret_amount = 50;
        @(negedge clk);
        chk("skip_ret_same_cycle", b_req_ready, 0);
        tick;
        b_ret_valid = 0;
        @(negedge clk);
        chk("skip_ready1", b_req_ready, 4'b0010);
        chk("skip_credit100", b_credit, 100);
        tick;
        b_req_valid = 4'b1000;
        @(negedge clk);
        chk("skip_credit0", b_credit, 0);
        chk("skip_gidx1", b_gnt_idx, 1);
        chk("skip_gamt", b_gnt_amount, 100);
        chk("skip_zero_amt", b_req_ready, 4'b1000);
        tick;
        b_req_valid = 0;
        repeat (3) tick;

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
